// File: rtl/pipe_skid_reg_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline register: flush, NOP bubbles, stall counter.
// Define PIPE_SKID_REG_NEG_EDGE_EN to clock every flop on the falling edge.
module pipe_skid_reg #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] NOP_VALUE   = '0,
  parameter int              CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 ctrl_flush,
  pipe_skid_reg_if.slave       in_if,
  pipe_skid_reg_if.master      out_if,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign in_fire    = in_if.valid & ~skid_valid;
  assign out_fire   = main_valid & out_if.ready;

  // in_ready is a pure function of state, never of out_ready
  assign in_if.ready  = ~skid_valid;
  assign out_if.valid = main_valid;
  assign out_if.data  = main_valid ? main_q : NOP_VALUE;
  assign occupancy    = state_q;
  assign stall_cycles = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    if (main_valid && !out_if.ready && stall_q != {CNT_W{1'b1}}) begin
      stall_d = stall_q + 1'b1;
    end
    if (ctrl_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_if.data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_if.data;
          end else if (in_fire) begin
            skid_d  = in_if.data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_REG_NEG_EDGE_EN
  always_ff @(negedge clock) begin
`else
  always_ff @(posedge clock) begin
`endif
    if (ctrl_reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (CNT_W=16 and CNT_W=2).
// Follows PIPE_SKID_REG_NEG_EDGE_EN for the active clock edge.
module tb_pipe_skid_reg;

  localparam int          W   = 32;
  localparam logic [W-1:0] NOP = 32'hDEAD_BEEF;
  localparam logic [W-1:0] RST = 32'h5A5A_5A5A;

  logic clock;
  logic ctrl_reset;
  logic ctrl_flush;
  logic [1:0]  occ0, occ1;
  logic [15:0] st0;
  logic [1:0]  st1;

  int checks;
  int failures;

  pipe_skid_reg_if #(.WIDTH(W)) i0 ();
  pipe_skid_reg_if #(.WIDTH(W)) o0 ();
  pipe_skid_reg_if #(.WIDTH(W)) i1 ();
  pipe_skid_reg_if #(.WIDTH(W)) o1 ();

  pipe_skid_reg #(
    .WIDTH(W), .RESET_VALUE(RST), .NOP_VALUE(NOP), .CNT_W(16)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_flush(ctrl_flush),
    .in_if(i0), .out_if(o0),
    .occupancy(occ0), .stall_cycles(st0)
  );

  pipe_skid_reg #(
    .WIDTH(W), .RESET_VALUE(RST), .NOP_VALUE(NOP), .CNT_W(2)
  ) dut2 (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_flush(ctrl_flush),
    .in_if(i1), .out_if(o1),
    .occupancy(occ1), .stall_cycles(st1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
`ifdef PIPE_SKID_REG_NEG_EDGE_EN
    @(negedge clock);
`else
    @(posedge clock);
`endif
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic r);
    i0.valid = v; i0.data = d; o0.ready = r;
    i1.valid = v; i1.data = d; o1.ready = r;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ovalid"}, {63'd0, o0.valid}, 64'd0);
    chk({tag, "_odata"}, {32'd0, o0.data}, {32'd0, NOP});
    chk({tag, "_iready"}, {63'd0, i0.ready}, 64'd1);
    chk({tag, "_occ"}, {62'd0, occ0}, 64'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ctrl_reset = 1'b1;
    ctrl_flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    ctrl_reset = 1'b0;
    tick();

    // reset / idle
    chk_idle("rst");
    chk("rst_stall", {48'd0, st0}, 64'd0);
    chk("rst_stall2", {62'd0, st1}, 64'd0);

    // streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b1);
      tick();
      chk($sformatf("strm%0d_data", i), {32'd0, o0.data}, 64'(i));
      chk($sformatf("strm%0d_valid", i), {63'd0, o0.valid}, 64'd1);
      chk($sformatf("strm%0d_ird", i), {63'd0, i0.ready}, 64'd1);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    chk_idle("strm_end");
    chk("strm_stall", {48'd0, st0}, 64'd0);

    // back-pressure: fill to FULL
    drive(1'b1, 32'hA, 1'b0);
    tick();
    chk("ab_occ1", {62'd0, occ0}, 64'd1);
    chk("ab_dataA", {32'd0, o0.data}, 64'hA);
    chk("ab_stall0", {48'd0, st0}, 64'd0);
    drive(1'b1, 32'hB, 1'b0);
    tick();
    chk("ab_occ2", {62'd0, occ0}, 64'd2);
    chk("ab_iready0", {63'd0, i0.ready}, 64'd0);
    chk("ab_holdA", {32'd0, o0.data}, 64'hA);
    chk("ab_stall1", {48'd0, st0}, 64'd1);
    drive(1'b1, 32'h77, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("ab_stall%0d", i), {48'd0, st0}, 64'(i));
      chk($sformatf("ab_hold%0d", i), {32'd0, o0.data}, 64'hA);
      chk($sformatf("ab_occ_h%0d", i), {62'd0, occ0}, 64'd2);
    end
    chk("sat_stall2", {62'd0, st1}, 64'd3);

    // drain in order
    drive(1'b0, 32'h99, 1'b1);
    tick();
    chk("drain_B", {32'd0, o0.data}, 64'hB);
    chk("drain_occ1", {62'd0, occ0}, 64'd1);
    chk("drain_iready", {63'd0, i0.ready}, 64'd1);
    tick();
    chk_idle("drain_end");
    chk("drain_stall", {48'd0, st0}, 64'd5);

    // flush while FULL with a pending 0xC
    drive(1'b1, 32'hD, 1'b0);
    tick();
    drive(1'b1, 32'hE, 1'b0);
    tick();
    chk("fl_occ2", {62'd0, occ0}, 64'd2);
    ctrl_flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    tick();
    ctrl_flush = 1'b0;
    chk("fl_occ", {62'd0, occ0}, 64'd0);
    chk("fl_ovalid", {63'd0, o0.valid}, 64'd0);
    chk("fl_odata", {32'd0, o0.data}, {32'd0, NOP});
    chk("fl_stall", {48'd0, st0}, 64'd7);
    drive(1'b0, 32'hC, 1'b1);
    tick();
    chk_idle("fl_after");
    chk("fl_stall_kept", {48'd0, st0}, 64'd7);
    chk("fl_stall2", {62'd0, st1}, 64'd3);

    // flush in ONE while both sides fire: in_data is dropped
    drive(1'b1, 32'h21, 1'b1);
    tick();
    chk("f1_data", {32'd0, o0.data}, 64'h21);
    ctrl_flush = 1'b1;
    drive(1'b1, 32'h22, 1'b1);
    tick();
    ctrl_flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk_idle("f1");

    // reset + flush mid-stream
    drive(1'b1, 32'h11, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    ctrl_reset = 1'b1;
    ctrl_flush = 1'b1;
    tick();
    chk_idle("rf");
    chk("rf_stall", {48'd0, st0}, 64'd0);
    chk("rf_stall2", {62'd0, st1}, 64'd0);
    ctrl_reset = 1'b0;
    ctrl_flush = 1'b0;
    drive(1'b1, 32'h33, 1'b1);
    tick();
    chk("post_data", {32'd0, o0.data}, 64'h33);
    chk("post_data2", {32'd0, o1.data}, 64'h33);
    chk("post_occ2", {62'd0, occ1}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register: the successor to the fixed 32-bit enable-gated stage register. It is a two-entry skid buffer with a valid/ready handshake, synchronous flush, bubble (NOP) insertion on the output and a saturating stall counter. It sits between processor pipeline stages (F/D, D/X, X/M, M/W) and replaces enable-only latching with back-pressure that does not drop data.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- RESET_VALUE, 0, value loaded into both data entries on reset
- NOP_VALUE, 0, value driven on out_data whenever out_valid=0
- CNT_W, 16, stall counter width (≥2)

Ports:
- clock  in  1  single clock for all state
- ctrl_reset  in  1  reset, synchronous, active-high
- ctrl_flush  in  1  synchronous flush: discard all held entries
- in_valid  in  1  upstream has data
- in_ready  out  1  stage can accept data
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage holds data for downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  head payload, or NOP_VALUE when empty
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry (drives out_data) and skid entry, each with a valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid. It is registered and has no combinational path from out_ready.
- out_valid = main_valid; out_data = main_valid ? main_data : NOP_VALUE.
- States, encoded by occupancy:
  - EMPTY (0): in_fire loads main and goes to ONE.
  - ONE (1):
    - in_fire & out_fire: main ← in_data, stay in ONE.
    - in_fire only: skid ← in_data, go to FULL.
    - out_fire only: go to EMPTY.
  - FULL (2): in_ready=0. out_fire moves skid to main and goes to ONE. Otherwise hold.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush:
  - Next state is EMPTY, and any in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle is still a completed transfer.
  - Data registers keep their values; only the valid bits clear.
- Reset: overrides flush and all handshakes. Both valid bits go to 0, both data entries load RESET_VALUE, stall_cycles goes to 0.
- stall_cycles:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_data=NOP_VALUE, stall_cycles=0.
- Latency:
  - Data accepted at edge N appears on out_data with out_valid=1 after edge N when the stage was empty.
  - In FULL it appears after the skid-to-main transfer.
- Throughput: one transfer per cycle sustained while out_ready=1.
- in_ready falls the cycle after entering FULL and rises the cycle after leaving it.
- Upstream may drop or change in_data while in_ready=0. The stage samples it only when in_fire is true.
- Downstream must treat out_data as stable while out_valid=1 and out_ready=0. The stage guarantees this.
- All state updates on a single active clock edge (see Configuration). No latches and no asynchronous paths.

## Configuration
- Macro: PIPE_SKID_REG_NEG_EDGE_EN.
- Defined: every flop, including reset sampling, updates on the falling edge of clock. This matches the existing falling-edge stage registers, so the stage can sit between rising-edge stages for half-cycle timing.
- Undefined: every flop updates on the rising edge.
- Behaviour, reset values and cycle counts are otherwise identical. Cycle counts are measured between active edges.

## Test plan
- Reset, then idle with in_valid=0: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0, stall_cycles=0.
- Stream 0x1,0x2,0x3,0x4 with out_ready=1 throughout: out_data shows 0x1..0x4 on consecutive cycles and in_ready stays 1.
- Push 0xA then 0xB with out_ready=0:
  - occupancy reaches 2, in_ready=0, out_data holds 0xA.
  - stall_cycles counts every held cycle.
  - Raising out_ready drains 0xA then 0xB in order, with no loss.
- Assert ctrl_flush while FULL, with in_valid=1 and in_data=0xC: next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE, and 0xC never appears.
- Assert ctrl_reset and ctrl_flush together mid-stream: the reset values above appear and stall_cycles=0. Run with CNT_W=2 and a stall of 5 cycles: stall_cycles saturates at 3.
- Repeat all scenarios with PIPE_SKID_REG_NEG_EDGE_EN defined: identical sequences, and all updates align to falling edges.
